// File: rtl/pipelined_add_sub_unit_if.sv
// Handshake and operand/result bundle for the pipelined add/subtract unit.
// The unit itself connects through the slave modport; the source/sink side uses master.
interface pipelined_add_sub_unit_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 4
) ();
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic [1:0]       op_in;
  logic [TAG_W-1:0] tag_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] result_out;
  logic [3:0]       flags_out;
  logic [TAG_W-1:0] tag_out;

  modport slave (
    input  valid_in, a_in, b_in, carry_in, op_in, tag_in, ready_in,
    output ready_out, valid_out, result_out, flags_out, tag_out
  );

  modport master (
    output valid_in, a_in, b_in, carry_in, op_in, tag_in, ready_in,
    input  ready_out, valid_out, result_out, flags_out, tag_out
  );
endinterface

// File: rtl/pipelined_add_sub_unit.sv
// Pipelined add/subtract unit producing LEGv8 NZCV flags. The carry chain is cut into
// CHUNK-bit slices, one slice resolved per stage; the last stage register drives the outputs.
module pipelined_add_sub_unit #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16,
  parameter int unsigned TAG_W = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_add_sub_unit_if.slave bus
);
  localparam int unsigned Stages = WIDTH / CHUNK;
  localparam int unsigned Last   = Stages - 1;

  logic [WIDTH-1:0] a_q   [Stages];
  logic [WIDTH-1:0] b_q   [Stages];
  logic [WIDTH-1:0] res_q [Stages];
  logic [TAG_W-1:0] tag_q [Stages];
  logic [Stages-1:0] carry_q;
  logic [Stages-1:0] valid_q;
  logic [2:0]        nzv_q;

  // Stage inputs (a_s/b_s/r_s/c_s/v_s/t_s) and stage results (r_d/c_d).
  logic [WIDTH-1:0] a_s   [Stages];
  logic [WIDTH-1:0] b_s   [Stages];
  logic [WIDTH-1:0] r_s   [Stages];
  logic [WIDTH-1:0] r_d   [Stages];
  logic [TAG_W-1:0] t_s   [Stages];
  logic [CHUNK:0]   slice_sum [Stages];
  logic [Stages-1:0] c_s;
  logic [Stages-1:0] c_d;
  logic [Stages-1:0] v_s;

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic             stall;
  logic [WIDTH-1:0] res_last;
  logic [2:0]       nzv_d;

  assign stall = valid_q[Last] && !bus.ready_in;

  always_comb begin
    b_eff = bus.op_in[0] ? ~bus.b_in : bus.b_in;
    cin   = bus.op_in[1] ? bus.carry_in : bus.op_in[0];
    for (int unsigned k = 0; k < Stages; k++) begin
      if (k == 0) begin
        a_s[k] = bus.a_in;
        b_s[k] = b_eff;
        r_s[k] = '0;
        c_s[k] = cin;
        v_s[k] = bus.valid_in;
        t_s[k] = bus.tag_in;
      end else begin
        a_s[k] = a_q[k-1];
        b_s[k] = b_q[k-1];
        r_s[k] = res_q[k-1];
        c_s[k] = carry_q[k-1];
        v_s[k] = valid_q[k-1];
        t_s[k] = tag_q[k-1];
      end
      slice_sum[k] = {1'b0, a_s[k][k*CHUNK +: CHUNK]} + {1'b0, b_s[k][k*CHUNK +: CHUNK]}
                   + (CHUNK + 1)'(c_s[k]);
      r_d[k] = r_s[k];
      r_d[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
      c_d[k] = slice_sum[k][CHUNK];
    end
  end

  // N, Z and V are resolved alongside the top slice; C is the top slice carry itself.
  always_comb begin
    res_last = r_d[Last];
    nzv_d    = {res_last[WIDTH-1],
                res_last == '0,
                (a_s[Last][WIDTH-1] == b_s[Last][WIDTH-1]) &&
                (res_last[WIDTH-1] != a_s[Last][WIDTH-1])};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < Stages; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
      nzv_q   <= '0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < Stages; k++) begin
        a_q[k]   <= a_s[k];
        b_q[k]   <= b_s[k];
        res_q[k] <= r_d[k];
        tag_q[k] <= t_s[k];
      end
      carry_q <= c_d;
      valid_q <= v_s;
      nzv_q   <= nzv_d;
    end
  end

  assign bus.ready_out  = !stall;
  assign bus.valid_out  = valid_q[Last];
  assign bus.result_out = res_q[Last];
  assign bus.flags_out  = {nzv_q[2], nzv_q[1], carry_q[Last], nzv_q[0]};
  assign bus.tag_out    = tag_q[Last];
endmodule

// File: doc/pipelined_add_sub_unit.md
Name: pipelined_add_sub_unit

Overview:
- Parametrised, pipelined integer add/subtract unit; next generation of the 64-bit combinational subtractor.
- Splits the carry chain into CHUNK-bit slices, one slice per pipeline stage. Accepts one operation per cycle and produces LEGv8 NZCV flags.
- Sits between the operand-read stage and writeback in the LEGv8 datapath.
- Valid/ready handshake on both sides; a tag travels with each operation.

Parameters:
WIDTH, 64, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 16, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (default 4).
TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
valid_in  input  1  operation presented this cycle
ready_out  output  1  unit can accept an operation this cycle
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
carry_in  input  1  carry input; used by ADC/SBC only
op_in  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC
tag_in  input  TAG_W  opaque tag
valid_out  output  1  result/flags/tag valid
ready_in  input  1  downstream accepts result
result_out  output  WIDTH  sum or difference, modulo 2^WIDTH
flags_out  output  4  {N,Z,C,V}
tag_out  output  TAG_W  tag of the operation in result_out

Behaviour:
- Reset: all stage valid bits, valid_out, result_out, flags_out and tag_out clear to 0 asynchronously; ready_out=1 while rst_n=0 is released. Any in-flight operations are discarded on reset assertion, including mid-pipeline.
- Arithmetic: the effective B operand and carry are selected by op_in:
  - ADD: B=b_in, cin=0
  - SUB: B=~b_in, cin=1
  - ADC: B=b_in, cin=carry_in
  - SBC: B=~b_in, cin=carry_in
  - result = a + B + cin, truncated to WIDTH bits.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C = carry out of bit WIDTH-1. For SUB, C=1 means no borrow (a>=b unsigned).
  - V = signed overflow: (a[msb]==B[msb]) && (result[msb]!=a[msb]).
- Pipeline:
  - Stage k (k = 0..STAGES-1) adds slice k of A and B with the carry registered from stage k-1.
  - Unprocessed upper slices of A and B are skewed forward unchanged; completed lower result slices are carried forward.
  - Stage 0 is combinational from the inputs into the first register.
- Latency: an operation accepted at rising edge E appears on the outputs (valid_out=1) after edge E+STAGES-1. Default: visible after the 4th edge counting E as the 1st.
- Throughput: one operation per cycle when ready_in=1.
- Handshake:
  - Accept occurs when valid_in && ready_out at a rising edge.
  - Global stall: stall = valid_out && !ready_in. While stalled, every stage register holds and ready_out=0. Bubbles are not compressed.
  - Transfer out occurs when valid_out && ready_in. If no new valid reaches the last stage on that edge, valid_out drops.
  - result_out, flags_out and tag_out are stable while valid_out=1 and ready_in=0.
- Ordering: results leave strictly in acceptance order; tag_out equals the tag_in of the same operation.
- Simultaneous events:
  - Accept and output transfer on the same edge are both performed.
  - valid_in while ready_out=0 is ignored; the source must hold.
- Boundary cases:
  - ADD of 2^WIDTH-1 and 1 gives result=0, Z=1, C=1, V=0.
  - SUB with a==b gives Z=1, C=1.
  - WIDTH==CHUNK is legal and gives a 1-stage pipeline.

Test Plan:
- SUB a=54, b=17 (WIDTH=64) -> result 37 (0x25), NZCV=0010, valid_out after edge E+3, tag returned.
- SUB a=54, b=-17 (0xFFFF_FFFF_FFFF_FFEF) -> result 71, NZCV=0000 (C=0, borrow); SUB a=10, b=17 -> 0xFFFF_FFFF_FFFF_FFF9, NZCV=1000.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> 0x8000_0000_0000_0000, NZCV=1001; ADC 0xFFFF_FFFF_FFFF_FFFF + 0 with carry_in=1 -> 0, NZCV=0110; SBC 5-3 with carry_in=0 -> 1, C=1.
- Back-to-back burst of 6 ops with tags 0..5, then ready_in=0 for 3 cycles mid-burst -> ready_out=0 during the stall, outputs held stable, all 6 results delivered in order with no loss or duplication.
- Carry crossing slice boundaries (CHUNK=16): ADD 0x0000_0000_FFFF_FFFF + 1 -> 0x0000_0001_0000_0000. Re-run with WIDTH=32, CHUNK=8 and WIDTH=16, CHUNK=16 -> correct results and latency STAGES.
- Assert rst_n=0 with 3 ops in flight -> valid_out=0 immediately. After release, no stale result is emitted and the first new op completes with correct latency.
